// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, parity modes and TX FSM encoding.
// Intended for reuse by the matching receiver.
package uart_pkg;

  localparam int unsigned BAUD_RATES [8] = '{
    9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
  };

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  function automatic int unsigned bit_div(input int unsigned clk_freq, input int unsigned code);
    return clk_freq / BAUD_RATES[code];
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses bit_tick every DIV cycles while enabled, restarting
// from zero whenever enable is low.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] baud_sel,
  output logic       bit_tick
);

  localparam int unsigned CntW = $clog2(CLK_FREQ / BAUD_RATES[0]);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CntW-1:0] div_m1;

  // Constant per table entry; the loop elaborates to a mux of constants.
  always_comb begin
    div_m1 = '0;
    for (int i = 0; i < 8; i++) begin
      if (baud_sel == 3'(i)) div_m1 = CntW'(bit_div(CLK_FREQ, i) - 1);
    end
  end

  assign bit_tick = en && (cnt_q == div_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (!en || bit_tick) cnt_d = '0;
    else                 cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DATA_W bits LSB first, optional
// parity, STOP_BITS stop bits; baud chosen per frame from the shared table.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] data_byte,
  input  logic              send_en,
  input  logic [2:0]        baud_set,
  output logic              Rs232_Tx,
  output logic              uart_state,
  output logic              Tx_Done
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [2:0]        baud_q, baud_d;
  logic              par_q, par_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              busy;
  logic              bit_tick;

  assign busy = (state_q != StIdle);

  uart_baud_tick #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud_tick (
    .clk     (Clk),
    .rst_n   (Rst),
    .en      (busy),
    .baud_sel(baud_q),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    par_d   = par_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (send_en) begin
          shift_d = data_byte;
          baud_d  = baud_set;
          par_d   = (PARITY == PAR_ODD) ? ~^data_byte : ^data_byte;
          cnt_d   = '0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_tick) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (cnt_q == 4'(DATA_W - 1)) begin
            cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            // Shift so the next data bit is always at index 1.
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (bit_tick) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_tick) begin
          if (cnt_q == 4'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      baud_q  <= '0;
      par_q   <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      par_q   <= par_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign Rs232_Tx   = tx_q;
  assign uart_state = busy;
  assign Tx_Done    = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Four transmitter configurations checked every cycle against a frame-level
// model, plus hand-computed waveforms for the key frames.
module tb_uart_tx_param;

  localparam int unsigned CF [4] = '{50_000_000, 5_000_000, 5_000_000, 50_000_000};
  localparam int unsigned DW [4] = '{8, 8, 8, 5};
  localparam int unsigned PA [4] = '{0, 2, 1, 0};
  localparam int unsigned SB [4] = '{1, 1, 1, 2};
  localparam int unsigned BAUDS [8] = '{
    9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
  };

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [3:0] send = '0;
  logic [8:0] data [4] = '{default: '0};
  logic [2:0] baud [4] = '{default: '0};
  logic [3:0] tx_w, busy_w, done_w;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_param #(
      .CLK_FREQ (CF[g]),
      .DATA_W   (DW[g]),
      .PARITY   (PA[g]),
      .STOP_BITS(SB[g])
    ) u_dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .data_byte (data[g][DW[g]-1:0]),
      .send_en   (send[g]),
      .baud_set  (baud[g]),
      .Rs232_Tx  (tx_w[g]),
      .uart_state(busy_w[g]),
      .Tx_Done   (done_w[g])
    );
  end

  // ---------------- reference model: whole frames as bit vectors ----------------
  int         t_m  [4] = '{default: 0};
  int         dv_m [4] = '{default: 1};
  int         nb_m [4] = '{default: 1};
  bit         act_m[4] = '{default: 1'b0};
  bit         done_m[4] = '{default: 1'b0};
  logic [15:0] fr_m [4] = '{default: '1};
  logic [3:0] exp_tx, exp_busy, exp_done;

  function automatic int nbits_of(input int k);
    return 1 + DW[k] + ((PA[k] != 0) ? 1 : 0) + SB[k];
  endfunction

  function automatic logic [15:0] frame_of(input int k, input logic [8:0] d);
    logic [15:0] f;
    int ones;
    int n;
    f = '1;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < DW[k]; i++) begin
      f[1+i] = d[i];
      ones += int'(d[i]);
    end
    n = 1 + DW[k];
    if (PA[k] == 2) f[n] = (ones % 2 == 1);
    if (PA[k] == 1) f[n] = (ones % 2 == 0);
    return f;
  endfunction

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int k = 0; k < 4; k++) begin
        act_m[k]  <= 1'b0;
        done_m[k] <= 1'b0;
        t_m[k]    <= 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        done_m[k] <= 1'b0;
        if (act_m[k]) begin
          if (t_m[k] + 1 == nb_m[k] * dv_m[k]) begin
            act_m[k]  <= 1'b0;
            done_m[k] <= 1'b1;
          end else begin
            t_m[k] <= t_m[k] + 1;
          end
        end else if (send[k]) begin
          act_m[k] <= 1'b1;
          t_m[k]   <= 0;
          dv_m[k]  <= CF[k] / BAUDS[baud[k]];
          nb_m[k]  <= nbits_of(k);
          fr_m[k]  <= frame_of(k, data[k]);
        end
      end
    end
  end

  always_comb begin
    exp_tx   = '1;
    exp_busy = '0;
    exp_done = '0;
    for (int k = 0; k < 4; k++) begin
      exp_tx[k]   = act_m[k] ? fr_m[k][t_m[k] / dv_m[k]] : 1'b1;
      exp_busy[k] = act_m[k];
      exp_done[k] = done_m[k];
    end
  end

  // ---------------- comparison helpers ----------------
  task automatic chk(input string name, input logic act, input logic expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, expv);
    end
  endtask

  always @(negedge Clk) begin
    for (int k = 0; k < 4; k++) begin
      total += 3;
      if (tx_w[k] !== exp_tx[k]) begin
        bad++;
        $display("FAIL cmp%0d tx @%0t: got %b want %b", k, $time, tx_w[k], exp_tx[k]);
      end
      if (busy_w[k] !== exp_busy[k]) begin
        bad++;
        $display("FAIL cmp%0d busy @%0t: got %b want %b", k, $time, busy_w[k], exp_busy[k]);
      end
      if (done_w[k] !== exp_done[k]) begin
        bad++;
        $display("FAIL cmp%0d done @%0t: got %b want %b", k, $time, done_w[k], exp_done[k]);
      end
    end
  end

  int done_cnt0 = 0;
  int done_cnt3 = 0;
  always @(negedge Clk) begin
    if (done_w[0]) done_cnt0++;
    if (done_w[3]) done_cnt3++;
  end

  // Returns on the negedge just after the accepting edge (frame time 0).
  task automatic send_frame(input int k, input logic [8:0] d, input logic [2:0] b);
    @(negedge Clk);
    send[k] = 1'b1;
    data[k] = d;
    baud[k] = b;
    @(negedge Clk);
    send[k] = 1'b0;
  endtask

  task automatic lit_frame(input int k, input logic [15:0] bits, input int nbits, input int div,
                           input string name);
    int t;
    t = 0;
    for (int i = 0; i < nbits; i++) begin
      while (t < i * div + div / 2) begin
        @(negedge Clk);
        t++;
      end
      chk($sformatf("%s bit%0d", name, i), tx_w[k], bits[i]);
    end
    while (t < nbits * div - 1) begin
      @(negedge Clk);
      t++;
    end
    chk({name, " last busy"}, busy_w[k], 1'b1);
    chk({name, " early done"}, done_w[k], 1'b0);
    @(negedge Clk);
    chk({name, " done"}, done_w[k], 1'b1);
    chk({name, " idle"}, busy_w[k], 1'b0);
    chk({name, " idle line"}, tx_w[k], 1'b1);
    @(negedge Clk);
    chk({name, " done width"}, done_w[k], 1'b0);
  endtask

  task automatic reset_pulse();
    #2 Rst = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("async rst tx%0d", k), tx_w[k], 1'b1);
      chk($sformatf("async rst busy%0d", k), busy_w[k], 1'b0);
    end
    @(negedge Clk);
    #2 Rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    repeat (3) @(negedge Clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset tx%0d", k), tx_w[k], 1'b1);
      chk($sformatf("reset busy%0d", k), busy_w[k], 1'b0);
      chk($sformatf("reset done%0d", k), done_w[k], 1'b0);
    end
    #2 Rst = 1'b1;

    // 8N1 at 115200 from 50 MHz: DIV 434, 4340-cycle frame.
    send_frame(0, 9'h09E, 3'd4);
    lit_frame(0, 16'b1100111100, 10, 434, "8n1_9e");

    // Even parity, 0x9E has five ones -> parity 1. DIV = 5e6/115200 = 43.
    send_frame(1, 9'h09E, 3'd4);
    lit_frame(1, 16'b11100111100, 11, 43, "even_9e");

    // Odd parity, 0x55 has four ones -> parity 1. DIV = 5e6/921600 = 5.
    send_frame(2, 9'h055, 3'd7);
    lit_frame(2, 16'b11010101010, 11, 5, "odd_55");

    // Even parity 0x55 -> parity 0, slowest baud; mid-frame send and input changes ignored.
    send_frame(1, 9'h055, 3'd0);
    fork
      lit_frame(1, 16'b10010101010, 11, 520, "even_55");
      begin
        repeat (1500) @(negedge Clk);
        send[1] = 1'b1;
        data[1] = 9'h1FF;
        baud[1] = 3'd7;
        @(negedge Clk);
        send[1] = 1'b0;
        repeat (1000) @(negedge Clk);
        data[1] = 9'h000;
        baud[1] = 3'd3;
      end
    join
    repeat (20) @(negedge Clk);
    chk("no second frame", busy_w[1], 1'b0);

    // 5 data bits, 2 stop bits, DIV 54: 432-cycle frame.
    send_frame(3, 9'h016, 3'd7);
    lit_frame(3, 16'b11101100, 8, 54, "5n2_16");

    // Reset mid-frame abandons it with no Tx_Done.
    send_frame(3, 9'h00F, 3'd7);
    repeat (200) @(negedge Clk);
    done_cnt3 = 0;
    reset_pulse();
    repeat (500) @(negedge Clk);
    chk("no done after rst", (done_cnt3 == 0), 1'b1);

    // Back-to-back: second send in the Tx_Done cycle.
    done_cnt0 = 0;
    send_frame(0, 9'h09E, 3'd7);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge Clk);
      if (done_w[0]) found = 1'b1;
    end
    chk("b2b first done seen", found, 1'b1);
    send[0] = 1'b1;
    data[0] = 9'h055;
    @(negedge Clk);
    send[0] = 1'b0;
    chk("b2b start line", tx_w[0], 1'b0);
    chk("b2b start busy", busy_w[0], 1'b1);
    repeat (700) @(negedge Clk);
    chk("b2b two done pulses", (done_cnt0 == 2), 1'b1);

    // Randomised traffic, with occasional asynchronous resets.
    for (int c = 0; c < 30000; c++) begin
      @(negedge Clk);
      for (int k = 0; k < 4; k++) begin
        data[k] = 9'($urandom);
        baud[k] = (k == 0 || k == 3) ? 3'(4 + $urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        send[k] = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 5999) == 0) reset_pulse();
    end
    @(negedge Clk);
    send = '0;
    repeat (6000) @(negedge Clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
# uart_tx_param

Parametrised UART transmitter: the next generation of the fixed 8N1 `uart` TX block. It serialises one word per `send_en` pulse onto `Rs232_Tx`. Data width, parity mode and stop-bit count are compile-time parameters; baud rate is selected at run time from an eight-entry table. It sits between the byte-producing logic and the board RS-232 pin, clocked from the 50 MHz system clock.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `DATA_W`, 8: data bits per frame. Legal range 5..9.
- `PARITY`, 0: parity mode. 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame. Legal values 1 or 2.

Ports:
- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  asynchronous, active-low reset.
- `data_byte`  in  DATA_W  word to send; sampled only on the accepting cycle.
- `send_en`  in  1  start request; one-cycle high pulse.
- `baud_set`  in  3  baud select, sampled with `data_byte`. Values 0..7 map to 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
- `Rs232_Tx`  out  1  serial line; idles high.
- `uart_state`  out  1  high while a frame is in progress.
- `Tx_Done`  out  1  one-cycle pulse at end of frame.

## Operation

- Bit period `DIV` = floor(`CLK_FREQ` / baud). `DIV` is a constant per table entry; the counter width is $clog2 of the 9600 entry.
- Reset values: `Rs232_Tx`=1, `uart_state`=0, `Tx_Done`=0. All counters and the FSM return to IDLE. Reset asserted mid-frame forces the line high immediately and abandons the frame; no `Tx_Done` is issued.
- FSM states and transitions:
  - IDLE: go to START when `send_en`=1.
  - START: go to DATA after DIV cycles.
  - DATA: go to PARITY after DATA_W bit periods if PARITY≠0, otherwise go to STOP.
  - PARITY: go to STOP after DIV cycles.
  - STOP: go to IDLE after STOP_BITS×DIV cycles.
- Accept: `send_en`=1 in IDLE latches `data_byte` and `baud_set` into internal registers. `send_en` outside IDLE is ignored: no queueing, no corruption of the frame in flight.
- Data is sent LSB first. Start bit is 0. Stop bits are 1.
- Parity is computed over the latched DATA_W bits. Even parity bit = XOR of all data bits. Odd parity bit = inverted XOR.
- Changes on `data_byte` or `baud_set` during a frame have no effect.
- Unused table entries do not exist: all 8 codes are valid.

## Timing

- `send_en` high at edge N. `Rs232_Tx` falls and `uart_state` rises at edge N+1 (both registered).
- Every bit, including each stop bit, is held exactly DIV cycles.
- Frame length F = DIV × (1 + DATA_W + (PARITY≠0) + STOP_BITS) cycles, measured from edge N+1.
- At edge N+1+F: `uart_state` falls and `Tx_Done` pulses high for exactly one cycle.
- Back-to-back: a `send_en` in the `Tx_Done` cycle is accepted. The next start bit begins on the following edge, giving zero idle bits between frames.
- `Rs232_Tx` is driven directly from a flop, with no combinational path to the pin.

## Structure

- Shared package `uart_pkg` holds:
  - the baud-rate constant array (8 entries);
  - the parity-mode localparams `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the FSM state encoding.
  The planned `uart_rx_param` reuses this package.
- Sub-module `uart_baud_tick`: takes the latched `baud_set` and an enable, and emits a one-cycle `bit_tick` every DIV cycles. It restarts on enable. The TX FSM and shift register stay in the top module.

## Test plan

- Default params (8N1), `baud_set`=4, DIV=434, `data_byte`=8'h9E:
  - line bits 0,0,1,1,1,1,0,0,1,1, each 434 cycles;
  - `Tx_Done` at cycle 4340 after start.
- PARITY=2, STOP_BITS=1, 8'h9E (five ones): parity bit=1; 11-bit frame = 4774 cycles.
- PARITY=1, 8'h55 (four ones): parity bit=1. PARITY=2, 8'h55: parity bit=0.
- `baud_set`=0 (DIV=5208):
  - `send_en` pulsed mid-frame is ignored; no second frame follows;
  - `data_byte` changed mid-frame leaves the serialised bits unchanged.
- Back-to-back: `send_en` in the `Tx_Done` cycle with 8'h55 after 8'h9E. The second start bit follows the first frame's stop bit with no gap; two `Tx_Done` pulses in total.
- DATA_W=5, STOP_BITS=2, `baud_set`=7 (DIV=54): 8-bit-period frame = 432 cycles. `Rst` asserted at cycle 200 drives `Rs232_Tx`=1 asynchronously, `uart_state`=0, and no `Tx_Done`.
